// File: rtl/disp_pkg.sv
// Shared constants and types for the 6-digit 7-segment scan controller.
package disp_pkg;

  localparam int NUM_DIG = 6;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [5:0] DIG_OFF  = 6'h3F;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  // Which digit pair flashes.
  typedef enum logic [1:0] {
    BLINK_NONE = 2'b00,
    BLINK_LO   = 2'b01,
    BLINK_MID  = 2'b10,
    BLINK_HI   = 2'b11
  } blink_sel_e;

endpackage

// File: rtl/disp_scan_ctrl_seg_decoder.sv
// BCD nibble to active-low {g,f,e,d,c,b,a} segment pattern; non-BCD shows a dash.
module seg_decoder
  import disp_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_n_o
);

  // Pure lookup; anything above 9 falls through to the dash pattern.
  always_comb begin
    seg_n_o = SEG_DASH;
    case (bcd_i)
      4'd0: seg_n_o = 7'h40;
      4'd1: seg_n_o = 7'h79;
      4'd2: seg_n_o = 7'h24;
      4'd3: seg_n_o = 7'h30;
      4'd4: seg_n_o = 7'h19;
      4'd5: seg_n_o = 7'h12;
      4'd6: seg_n_o = 7'h02;
      4'd7: seg_n_o = 7'h78;
      4'd8: seg_n_o = 7'h00;
      4'd9: seg_n_o = 7'h10;
      default: seg_n_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 6-digit 7-segment scan controller.
// Input word is snapshotted once per frame; each digit slot starts with a
// short all-off window to suppress ghosting; selected digit pairs flash.
// Optional macro DISP_COLON_DP_EN: drive decimal points on digits 2 and 4
// as flashing separators; without it dp_n is constant 1.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_DIV     = 16,
  parameter int BLANK_CYC    = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        disp_en,
  input  logic [23:0] time_date,
  input  logic [1:0]  blink,
  output logic [6:0]  seg_n,
  output logic [5:0]  dig_n,
  output logic        frame_start,
  output logic        dp_n
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [2:0]    DIG_LAST = 3'(NUM_DIG - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    dig_idx_q, dig_idx_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [23:0]   shadow_td_q, shadow_td_d;
  blink_sel_e    shadow_blink_q, shadow_blink_d;

  logic [6:0] seg_q, seg_d;
  logic [5:0] dig_q, dig_d;
  logic       frame_start_q;

  logic       slot_end, frame_wrap;
  logic       in_window, pair_sel, lit;
  logic [3:0] cur_bcd;
  logic [6:0] dec_seg;

  assign slot_end   = (cnt_q == CNT_LAST);
  assign frame_wrap = slot_end && (dig_idx_q == DIG_LAST);

  // Scan/frame/blink counters and the once-per-frame input snapshot.
  always_comb begin
    cnt_d          = cnt_q + 1'b1;
    dig_idx_d      = dig_idx_q;
    frame_cnt_d    = frame_cnt_q;
    blink_phase_d  = blink_phase_q;
    shadow_td_d    = shadow_td_q;
    shadow_blink_d = shadow_blink_q;
    if (slot_end) begin
      cnt_d     = '0;
      dig_idx_d = (dig_idx_q == DIG_LAST) ? 3'd0 : dig_idx_q + 3'd1;
    end
    if (frame_wrap) begin
      shadow_td_d    = time_date;
      shadow_blink_d = blink_sel_e'(blink);
      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // De-ghost window: with no blank cycles every count is inside the lit window.
  generate
    if (BLANK_CYC == 0) begin : g_no_blank
      assign in_window = 1'b1;
    end else begin : g_blank
      assign in_window = (cnt_q >= CW'(BLANK_CYC));
    end
  endgenerate

  // Does the snapshotted blink field cover the digit currently scanned?
  always_comb begin
    pair_sel = 1'b0;
    case (shadow_blink_q)
      BLINK_LO:  pair_sel = (dig_idx_q[2:1] == 2'd0);
      BLINK_MID: pair_sel = (dig_idx_q[2:1] == 2'd1);
      BLINK_HI:  pair_sel = (dig_idx_q[2:1] == 2'd2);
      default:   pair_sel = 1'b0;
    endcase
  end

  assign lit = in_window & disp_en & ~(blink_phase_q & pair_sel);

  // Select the nibble of the digit being scanned from the snapshot.
  always_comb begin
    cur_bcd = shadow_td_q[3:0];
    case (dig_idx_q)
      3'd1:    cur_bcd = shadow_td_q[7:4];
      3'd2:    cur_bcd = shadow_td_q[11:8];
      3'd3:    cur_bcd = shadow_td_q[15:12];
      3'd4:    cur_bcd = shadow_td_q[19:16];
      3'd5:    cur_bcd = shadow_td_q[23:20];
      default: cur_bcd = shadow_td_q[3:0];
    endcase
  end

  seg_decoder u_seg_decoder (
    .bcd_i   (cur_bcd),
    .seg_n_o (dec_seg)
  );

  assign seg_d = lit ? dec_seg : SEG_OFF;
  assign dig_d = lit ? ~(6'b000001 << dig_idx_q) : DIG_OFF;

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      dig_idx_q      <= '0;
      frame_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      shadow_td_q    <= '0;
      shadow_blink_q <= BLINK_NONE;
      seg_q          <= SEG_OFF;
      dig_q          <= DIG_OFF;
      frame_start_q  <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      dig_idx_q      <= dig_idx_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_phase_q  <= blink_phase_d;
      shadow_td_q    <= shadow_td_d;
      shadow_blink_q <= shadow_blink_d;
      seg_q          <= seg_d;
      dig_q          <= dig_d;
      frame_start_q  <= frame_wrap;
    end
  end

  assign seg_n       = seg_q;
  assign dig_n       = dig_q;
  assign frame_start = frame_start_q;

`ifdef DISP_COLON_DP_EN
  logic dp_q, dp_d;
  assign dp_d = ~(lit & ~blink_phase_q & ((dig_idx_q == 3'd2) | (dig_idx_q == 3'd4)));

  // Separator dots follow the lit window of digits 2 and 4, flashing with blink_phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dp_q <= 1'b1;
    else        dp_q <= dp_d;
  end

  assign dp_n = dp_q;
`else
  assign dp_n = 1'b1;
`endif

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl (SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2).
`timescale 1ns/1ps
module tb_disp_scan_ctrl;

  localparam int SCAN_DIV     = 4;
  localparam int BLANK_CYC    = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_CYC    = SCAN_DIV * 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_en = 1'b0;
  logic [23:0] time_date = '0;
  logic [1:0]  blink = '0;
  logic [6:0]  seg_n;
  logic [5:0]  dig_n;
  logic        frame_start;
  logic        dp_n;

  int n_tests = 0;
  int n_fail  = 0;
  int fs_count = 0;
  int pos = 0;
  bit synced = 1'b0;

  typedef struct {
    int         slot;
    logic [5:0] dig;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  disp_scan_ctrl #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYC    (BLANK_CYC),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .disp_en     (disp_en),
    .time_date   (time_date),
    .blink       (blink),
    .seg_n       (seg_n),
    .dig_n       (dig_n),
    .frame_start (frame_start),
    .dp_n        (dp_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // blink_phase after w frame wraps with BLINK_FRAMES=2
  function automatic bit phase_now();
    return ((fs_count / 2) % 2) != 0;
  endfunction

  // Queue the end-of-slot appearance of all six digits for the current frame.
  task automatic push_frame(input logic [23:0] td, input logic [5:0] dark, input bit phase);
    exp_t e;
    for (int s = 0; s < 6; s++) begin
      e.slot = s;
      if (dark[s]) begin
        e.dig = 6'h3F;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
      end else begin
        e.dig = ~(6'b000001 << s);
        e.seg = seg_of(td[s*4 +: 4]);
`ifdef DISP_COLON_DP_EN
        e.dp  = !(!phase && (s == 2 || s == 4));
`else
        e.dp  = 1'b1;
`endif
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_frame();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_start && k < 2 * FRAME_CYC);
    if (!frame_start) begin
      n_tests++;
      n_fail++;
      $display("FAIL frame_wait: no frame_start within %0d cycles, required a pulse", k);
    end
  endtask

  // Leaves the caller one cycle after frame_start (frame position 1).
  task automatic sync_frame();
    wait_frame();
    @(negedge clk);
  endtask

  // Monitor: tracks frame position from frame_start and checks each slot's
  // blank cycle and last lit cycle against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      synced   = 1'b0;
      pos      = 0;
      fs_count = 0;
      exp_q.delete();
    end else begin
      if (synced) begin
        pos++;
        if (pos >= SCAN_DIV && pos <= FRAME_CYC && (pos % SCAN_DIV) == 0 && exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check($sformatf("slot%0d_dig", mon_e.slot), 32'(dig_n), 32'(mon_e.dig));
          check($sformatf("slot%0d_seg", mon_e.slot), 32'(seg_n), 32'(mon_e.seg));
          check($sformatf("slot%0d_dp", mon_e.slot), 32'(dp_n), 32'(mon_e.dp));
        end
        if ((pos % SCAN_DIV) == 1 && pos < FRAME_CYC) begin
          check($sformatf("blank_pos%0d", pos), 32'({dig_n, seg_n}), 32'({6'h3F, 7'h7F}));
        end
      end
      if (frame_start) begin
        fs_count++;
        if (synced) check("frame_period", 32'(pos), 32'(FRAME_CYC));
        synced = 1'b1;
        pos    = 0;
      end
    end
  end

  initial begin
    // Reset state and scan start
    rst_n = 1'b0;
    disp_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg_n), 32'(7'h7F));
    check("rst_dig", 32'(dig_n), 32'(6'h3F));
    check("rst_fs", 32'(frame_start), 32'(1'b0));
    check("rst_dp", 32'(dp_n), 32'(1'b1));
    rst_n = 1'b1;
    @(negedge clk);
    check("start_blank_dig", 32'(dig_n), 32'(6'h3F));
    @(negedge clk);
    check("start_dig0", 32'(dig_n), 32'(6'h3E));
    check("start_seg0", 32'(seg_n), 32'(7'h40));
    repeat (3) @(negedge clk);
    check("dig1_blank", 32'(dig_n), 32'(6'h3F));
    @(negedge clk);
    check("dig1_sel", 32'(dig_n), 32'(6'h3D));

    // Digit decode and scan order
    time_date = 24'h123456;
    sync_frame();
    push_frame(24'h123456, 6'h00, phase_now());
    // Mid-frame change must not tear the current frame
    repeat (9) @(negedge clk);
    check("mid_dig2_lit", 32'(dig_n), 32'(6'h3B));
    time_date = 24'h000000;
    sync_frame();
    push_frame(24'h000000, 6'h00, phase_now());

    // Blink on digits 3:2 over two full blink periods
    time_date = 24'h123456;
    blink = 2'b10;
    for (int f = 0; f < 4; f++) begin
      bit ph;
      sync_frame();
      ph = phase_now();
      push_frame(24'h123456, ph ? 6'b001100 : 6'b000000, ph);
    end
    blink = 2'b00;
    sync_frame();
    push_frame(24'h123456, 6'h00, phase_now());

    // Non-BCD nibble shows a dash
    time_date = 24'h00000A;
    sync_frame();
    push_frame(24'h00000A, 6'h00, phase_now());

    // Display disable mid-slot, full dark frame, re-enable mid-frame
    time_date = 24'h000000;
    sync_frame();
    push_frame(24'h000000, 6'b111100, phase_now());
    repeat (9) @(negedge clk);
    disp_en = 1'b0;
    @(negedge clk);
    check("en_off_dig", 32'(dig_n), 32'(6'h3F));
    check("en_off_seg", 32'(seg_n), 32'(7'h7F));
    sync_frame();
    push_frame(24'h000000, 6'h3F, phase_now());
    sync_frame();
    push_frame(24'h000000, 6'b000011, phase_now());
    repeat (9) @(negedge clk);
    disp_en = 1'b1;

    // Asynchronous reset in the middle of a lit slot
    sync_frame();
    repeat (5) @(negedge clk);
    check("pre_rst_dig1", 32'(dig_n), 32'(6'h3D));
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_seg", 32'(seg_n), 32'(7'h7F));
    check("async_rst_dig", 32'(dig_n), 32'(6'h3F));
    check("async_rst_dp", 32'(dp_n), 32'(1'b1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_blank", 32'(dig_n), 32'(6'h3F));
    @(negedge clk);
    check("restart_dig0", 32'(dig_n), 32'(6'h3E));
    sync_frame();
    push_frame(24'h000000, 6'h00, phase_now());
    sync_frame();
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
